sum_of_products_neg: RTL and testbench
======================================

Name: sum_of_products_neg

Overview:
Parametrised successor to the fixed four-multiplier adder in the DSP negative-edge design suite. NUM_LANES unsigned multipliers feed an adder tree. An optional accumulator sits at the output, with a choice of saturating or wrapping overflow. All state is clocked on the falling edge of clk. A valid strobe travels with the data so that streaming benches can check latency exactly.

Parameters:
INPUT_WIDTH, 14, width of each unsigned lane operand
NUM_LANES, 4, number of multiplier lanes; legal range 1..16
OUTPUT_WIDTH, 40, width of y and the accumulator; must be >= 2*INPUT_WIDTH + clog2(NUM_LANES)
SATURATE, 1, 1 = clamp accumulator at max on overflow; 0 = wrap modulo 2^OUTPUT_WIDTH

Ports:
clk  input  1  clock; every register updates on negedge clk
reset  input  1  asynchronous, active-low reset
in_valid  input  1  sample-valid strobe, sampled on negedge clk
acc_en  input  1  per-sample mode: 0 = load sum, 1 = add sum to running y
a  input  NUM_LANES*INPUT_WIDTH  lane i operand at a[i*INPUT_WIDTH +: INPUT_WIDTH]
b  input  NUM_LANES*INPUT_WIDTH  lane i operand, same packing as a
y  output  OUTPUT_WIDTH  registered sum / accumulator
out_valid  output  1  high for one cycle when y has just been updated
ovf  output  1  sticky overflow flag

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - all pipeline registers, y, out_valid and ovf go to 0.
  - in-flight samples are discarded; nothing emerges after release.
- Pipeline, all stages on negedge:
  - S0 registers a, b, in_valid, acc_en.
  - S1 registers NUM_LANES products, each 2*INPUT_WIDTH bits.
  - S2 registers the adder-tree sum, width 2*INPUT_WIDTH + clog2(NUM_LANES), zero-extended.
  - S3 updates y, out_valid and ovf.
- Latency: a sample captured at negedge k appears on y with out_valid=1 after negedge k+3.
- Throughput: one sample per cycle. Back-to-back valid samples are fully supported; there are no stalls and no backpressure.
- Valid and mode handling:
  - valid and acc_en propagate with their sample.
  - Bubbles (in_valid=0) propagate as bubbles: at S3, y and ovf hold and out_valid=0.
- S3 update for a valid sample with acc_en=0:
  - y <= sum.
  - ovf <= 0. A load clears the sticky flag.
- S3 update for a valid sample with acc_en=1:
  - t = y + sum, computed at OUTPUT_WIDTH+1 bits.
  - If t > 2^OUTPUT_WIDTH-1:
    - ovf <= 1.
    - y <= all ones when SATURATE=1.
    - y <= t mod 2^OUTPUT_WIDTH when SATURATE=0.
  - Otherwise y <= t and ovf holds.
- Simultaneous events:
  - Reset asserted on the same negedge as a valid sample: reset wins.
  - acc_en=1 on the first sample after reset accumulates onto y=0.
- Arithmetic is unsigned throughout. No truncation occurs before S3 when the OUTPUT_WIDTH constraint holds.
- Illegal OUTPUT_WIDTH is rejected at elaboration: the block must fail elaboration.
- Operands are not re-sampled between negedges. Changing a or b after a negedge does not affect the captured sample.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, a and b nonzero, then release.
  - Required: y=0, out_valid=0, ovf=0 throughout reset.
  - Required: no out_valid pulse for 3 negedges after release.
- Uniform lanes and latency: all four lanes a=5, b=10, in_valid=1 for one cycle, acc_en=0.
  - Required: y=200 and out_valid=1 exactly 3 negedges after capture.
  - Required: out_valid=0 on the next cycle, y holds 200.
- Mixed lanes, streaming:
  - Stimulus: lanes a={0,1,2,3}, b={1,1,2,3} (sum 14); next cycle all lanes a=b=0x3ff (sum 4,186,116); then a bubble; then a=3, b=1 on all lanes (sum 12).
  - Required: y sequence 14, 4186116, (hold), 12 on consecutive valid outputs.
  - Required: out_valid low only on the bubble cycle.
- Accumulate: three valid samples of sum 14 with acc_en=1 following a load of 14 with acc_en=0.
  - Required: y goes 14, 28, 42, 56; ovf stays 0.
- Saturation, OUTPUT_WIDTH=30, SATURATE=1: all lanes a=b=0x3fff (sum 1,073,610,756), first with acc_en=0, then with acc_en=1.
  - Required: y=1073610756, then y=1073741823 with ovf=1.
  - Required: a following acc_en=0 sample of sum 14 gives y=14 and ovf=0.
- Wrap, OUTPUT_WIDTH=30, SATURATE=0: same stimulus as saturation.
  - Required: second y=1073479688 and ovf=1.
  - Required: reset asserted mid-stream clears y, ovf and all in-flight samples.

Source files
------------

// File: rtl/sum_of_products_neg_if.sv
// Sample/result bundle for sum_of_products_neg: lane operands in, registered sum,
// valid strobe and sticky overflow out.
interface sum_of_products_neg_if #(
    parameter int INPUT_WIDTH  = 14,
    parameter int NUM_LANES    = 4,
    parameter int OUTPUT_WIDTH = 40
);
    logic                              in_valid;
    logic                              acc_en;
    logic [NUM_LANES*INPUT_WIDTH-1:0]  a;
    logic [NUM_LANES*INPUT_WIDTH-1:0]  b;
    logic [OUTPUT_WIDTH-1:0]           y;
    logic                              out_valid;
    logic                              ovf;

    modport master (
        output in_valid, acc_en, a, b,
        input  y, out_valid, ovf
    );

    modport slave (
        input  in_valid, acc_en, a, b,
        output y, out_valid, ovf
    );
endinterface

// File: rtl/sum_of_products_neg.sv
// NUM_LANES unsigned multipliers into an adder tree with an optional saturating or
// wrapping accumulator; every register is clocked on the falling edge of clk.
module sum_of_products_neg #(
    parameter int INPUT_WIDTH  = 14,
    parameter int NUM_LANES    = 4,
    parameter int OUTPUT_WIDTH = 40,
    parameter int SATURATE     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sum_of_products_neg_if.slave bus
);
    localparam int PROD_W = 2 * INPUT_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(NUM_LANES);
    localparam int VEC_W  = NUM_LANES * INPUT_WIDTH;

    if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
        $error("sum_of_products_neg: NUM_LANES must be in 1..16");
    end
    if (OUTPUT_WIDTH < SUM_W) begin : g_bad_width
        $error("sum_of_products_neg: OUTPUT_WIDTH too narrow for the full sum");
    end

    // Resolve an accumulator overflow: clamp to all ones or keep the low bits.
    function automatic logic [OUTPUT_WIDTH-1:0] acc_limit(input logic [OUTPUT_WIDTH:0] t);
        if (t[OUTPUT_WIDTH] && SATURATE != 0) begin
            return '1;
        end
        return t[OUTPUT_WIDTH-1:0];
    endfunction

    logic [VEC_W-1:0]        a_p0, b_p0;
    logic                    vld_p0, acc_p0;
    logic [PROD_W-1:0]       prod_p1 [NUM_LANES];
    logic                    vld_p1, acc_p1;
    logic [SUM_W-1:0]        sum_p2;
    logic                    vld_p2, acc_p2;
    logic [OUTPUT_WIDTH-1:0] y_q;
    logic                    out_valid_q;
    logic                    ovf_q;

    logic [SUM_W-1:0]        tree_sum;
    logic [OUTPUT_WIDTH:0]   acc_sum;

    // S0: capture operands and control for this sample
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            a_p0   <= '0;
            b_p0   <= '0;
            vld_p0 <= 1'b0;
            acc_p0 <= 1'b0;
        end else begin
            a_p0   <= bus.a;
            b_p0   <= bus.b;
            vld_p0 <= bus.in_valid;
            acc_p0 <= bus.acc_en;
        end
    end

    // S1: per-lane full-width products
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                prod_p1[i] <= '0;
            end
            vld_p1 <= 1'b0;
            acc_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                prod_p1[i] <= a_p0[i*INPUT_WIDTH +: INPUT_WIDTH] * b_p0[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
            vld_p1 <= vld_p0;
            acc_p1 <= acc_p0;
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            tree_sum = tree_sum + SUM_W'(prod_p1[i]);
        end
    end

    // S2: lane sum, wide enough that it can never carry out
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            sum_p2 <= '0;
            vld_p2 <= 1'b0;
            acc_p2 <= 1'b0;
        end else begin
            sum_p2 <= tree_sum;
            vld_p2 <= vld_p1;
            acc_p2 <= acc_p1;
        end
    end

    always_comb begin
        acc_sum = {1'b0, y_q} + (OUTPUT_WIDTH + 1)'(sum_p2);
    end

    // S3: load or accumulate; bubbles leave y and ovf untouched
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= vld_p2;
            if (vld_p2) begin
                if (!acc_p2) begin
                    y_q   <= OUTPUT_WIDTH'(sum_p2);
                    ovf_q <= 1'b0;
                end else begin
                    y_q <= acc_limit(acc_sum);
                    if (acc_sum[OUTPUT_WIDTH]) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sum_of_products_neg.sv
// Directed bench for sum_of_products_neg: default build plus 30-bit saturating and
// wrapping builds, driven through a shared stimulus table.
module tb_sum_of_products_neg;
    localparam int IW = 14;
    localparam int NL = 4;

    logic            clk = 1'b0;
    logic            reset;
    int              sel;
    logic            vld_s, acc_s;
    logic [NL*IW-1:0] a_s, b_s;

    int n_cmp = 0;
    int n_bad = 0;

    sum_of_products_neg_if #(.INPUT_WIDTH(IW), .NUM_LANES(NL), .OUTPUT_WIDTH(40)) if0 ();
    sum_of_products_neg_if #(.INPUT_WIDTH(IW), .NUM_LANES(NL), .OUTPUT_WIDTH(30)) if1 ();
    sum_of_products_neg_if #(.INPUT_WIDTH(IW), .NUM_LANES(NL), .OUTPUT_WIDTH(30)) if2 ();

    sum_of_products_neg #(.INPUT_WIDTH(IW), .NUM_LANES(NL), .OUTPUT_WIDTH(40), .SATURATE(1))
        dut_def (.clk(clk), .reset(reset), .bus(if0.slave));
    sum_of_products_neg #(.INPUT_WIDTH(IW), .NUM_LANES(NL), .OUTPUT_WIDTH(30), .SATURATE(1))
        dut_sat (.clk(clk), .reset(reset), .bus(if1.slave));
    sum_of_products_neg #(.INPUT_WIDTH(IW), .NUM_LANES(NL), .OUTPUT_WIDTH(30), .SATURATE(0))
        dut_wrap (.clk(clk), .reset(reset), .bus(if2.slave));

    assign if0.in_valid = vld_s && (sel == 0);
    assign if1.in_valid = vld_s && (sel == 1);
    assign if2.in_valid = vld_s && (sel == 2);
    assign if0.acc_en = acc_s;
    assign if1.acc_en = acc_s;
    assign if2.acc_en = acc_s;
    assign if0.a = a_s;
    assign if1.a = a_s;
    assign if2.a = a_s;
    assign if0.b = b_s;
    assign if1.b = b_s;
    assign if2.b = b_s;

    always #5 clk = ~clk;

    logic [39:0] y_sel;
    logic        ov_sel, ovf_sel;
    always_comb begin
        y_sel   = {{10{1'b0}}, if1.y};
        ov_sel  = if1.out_valid;
        ovf_sel = if1.ovf;
        if (sel == 0) begin
            y_sel   = if0.y;
            ov_sel  = if0.out_valid;
            ovf_sel = if0.ovf;
        end else if (sel == 2) begin
            y_sel   = {{10{1'b0}}, if2.y};
            ov_sel  = if2.out_valid;
            ovf_sel = if2.ovf;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NL*IW-1:0] lanes(input int x0, input int x1, input int x2, input int x3);
        return {IW'(x3), IW'(x2), IW'(x1), IW'(x0)};
    endfunction

    logic              s_vld [8];
    logic              s_acc [8];
    logic [NL*IW-1:0]  s_a   [8];
    logic [NL*IW-1:0]  s_b   [8];
    logic              e_vld [8];
    logic [39:0]       e_y   [8];
    logic              e_ovf [8];

    task automatic put(input int i, input logic v, input logic acc,
                       input logic [NL*IW-1:0] av, input logic [NL*IW-1:0] bv,
                       input logic ev, input logic [39:0] ey, input logic eo);
        s_vld[i] = v;  s_acc[i] = acc; s_a[i] = av; s_b[i] = bv;
        e_vld[i] = ev; e_y[i]   = ey;  e_ovf[i] = eo;
    endtask

    task automatic run_stream(input string tag, input int n);
        for (int i = 0; i < n + 4; i++) begin
            @(posedge clk);
            if (i < 4) begin
                check_eq({tag, "_early_vld"}, 64'(ov_sel), 64'(0));
            end else begin
                check_eq($sformatf("%s_vld%0d", tag, i - 4), 64'(ov_sel), 64'(e_vld[i-4]));
                check_eq($sformatf("%s_y%0d", tag, i - 4), 64'(y_sel), 64'(e_y[i-4]));
                check_eq($sformatf("%s_ovf%0d", tag, i - 4), 64'(ovf_sel), 64'(e_ovf[i-4]));
            end
            if (i < n) begin
                vld_s = s_vld[i]; acc_s = s_acc[i]; a_s = s_a[i]; b_s = s_b[i];
            end else begin
                vld_s = 1'b0; acc_s = 1'b0;
            end
        end
    endtask

    logic [NL*IW-1:0] mix_a, mix_b, ff_l, max_l;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mix_a = lanes(0, 1, 2, 3);
        mix_b = lanes(1, 1, 2, 3);
        ff_l  = lanes(16'h3ff, 16'h3ff, 16'h3ff, 16'h3ff);
        max_l = lanes(16'h3fff, 16'h3fff, 16'h3fff, 16'h3fff);

        sel = 0; reset = 1'b1; vld_s = 1'b1; acc_s = 1'b0;
        a_s = lanes(7, 7, 7, 7); b_s = lanes(9, 9, 9, 9);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            check_eq("rst_y", 64'(if0.y), 64'(0));
            check_eq("rst_vld", 64'(if0.out_valid), 64'(0));
            check_eq("rst_ovf", 64'(if0.ovf), 64'(0));
        end
        reset = 1'b1; vld_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            check_eq("post_rst_vld", 64'(if0.out_valid), 64'(0));
            check_eq("post_rst_y", 64'(if0.y), 64'(0));
        end

        put(0, 1, 0, lanes(5, 5, 5, 5), lanes(10, 10, 10, 10), 1, 200, 0);
        put(1, 0, 0, '0, '0, 0, 200, 0);
        run_stream("uniform", 2);

        put(0, 1, 0, mix_a, mix_b, 1, 14, 0);
        put(1, 1, 0, ff_l, ff_l, 1, 4186116, 0);
        put(2, 0, 0, '0, '0, 0, 4186116, 0);
        put(3, 1, 0, lanes(3, 3, 3, 3), lanes(1, 1, 1, 1), 1, 12, 0);
        run_stream("mixed", 4);

        put(0, 1, 0, mix_a, mix_b, 1, 14, 0);
        put(1, 1, 1, mix_a, mix_b, 1, 28, 0);
        put(2, 1, 1, mix_a, mix_b, 1, 42, 0);
        put(3, 1, 1, mix_a, mix_b, 1, 56, 0);
        run_stream("accum", 4);

        sel = 1;
        put(0, 1, 0, max_l, max_l, 1, 1073610756, 0);
        put(1, 1, 1, max_l, max_l, 1, 1073741823, 1);
        put(2, 1, 0, mix_a, mix_b, 1, 14, 0);
        run_stream("sat", 3);

        sel = 2;
        put(0, 1, 0, max_l, max_l, 1, 1073610756, 0);
        put(1, 1, 1, max_l, max_l, 1, 1073479688, 1);
        run_stream("wrap", 2);

        // Fill the pipe, then pull reset between edges with samples in flight.
        @(posedge clk);
        vld_s = 1'b1; acc_s = 1'b1; a_s = max_l; b_s = max_l;
        @(posedge clk);
        @(posedge clk);
        vld_s = 1'b0; acc_s = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_y", 64'(if2.y), 64'(0));
        check_eq("mid_rst_ovf", 64'(if2.ovf), 64'(0));
        check_eq("mid_rst_vld", 64'(if2.out_valid), 64'(0));
        @(posedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            check_eq("flush_vld", 64'(if2.out_valid), 64'(0));
            check_eq("flush_y", 64'(if2.y), 64'(0));
            check_eq("flush_ovf", 64'(if2.ovf), 64'(0));
        end

        put(0, 1, 1, mix_a, mix_b, 1, 14, 0);
        run_stream("acc_first", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
